// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. Each grant allows at most MAX_BURST words before the
// grant is re-arbitrated, so no producer can starve the others.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   req_valid     per-producer word available
//   req_data      flattened producer words, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-producer word accepted this cycle (one-hot or zero)
//   fifo_full     FIFO full flag
//   fifo_wr       FIFO write enable
//   fifo_data_in  FIFO write data
//   grant_id      current grant holder (valid while busy)
//   busy          high while a grant is held (BURST state)
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                 state;
    logic [ID_W-1:0]        last_grant;
    logic [CNT_W-1:0]       burst_cnt;

    logic [ID_W-1:0]        sel;
    logic                   found;
    logic [DATA_WIDTH-1:0]  words [NUM_REQ];
    logic                   cur_valid;
    logic                   xfer;

    // Rotating-priority search starting just after the last grant holder.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] cand;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx  = (32'(last_grant) + k) % NUM_REQ;
            cand = ID_W'(idx);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Unpack the flattened producer words.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign busy      = (state == BURST);
    assign cur_valid = req_valid[grant_id];
    assign xfer      = busy & cur_valid & ~fifo_full;

    // Write path is combinational from the grant; reset forces it quiet.
    assign fifo_wr      = xfer & ~reset;
    assign fifo_data_in = (busy && !reset) ? words[grant_id] : '0;

    always_comb begin
        req_ready = '0;
        if (fifo_wr) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // Arbitration FSM: one idle cycle per grant, bursts bounded by MAX_BURST.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant_id   <= '0;
            burst_cnt  <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id   <= sel;
                        last_grant <= sel;
                        burst_cnt  <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (!cur_valid) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                            state <= IDLE;
                        end else begin
                            burst_cnt <= burst_cnt + CNT_W'(1);
                        end
                    end
                    // fifo_full with a valid holder: stall, everything held
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8).
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr      (fifo_wr),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Producer model: remaining words and next sequence number per producer.
    int rem [4];
    int seq [4];

    logic       c_wr;
    logic [3:0] c_rdy;
    logic       c_busy;
    logic [1:0] c_gid;
    logic [7:0] c_data;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       full;
        logic       e_wr;
        logic [3:0] e_rdy;
        logic [7:0] e_data;
        logic       e_busy;
        logic [1:0] e_gid;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
    endtask

    // One cycle driven from the producer model, with protocol checks.
    task automatic tick(input logic rst, input logic full);
        reset     = rst;
        fifo_full = full;
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (rem[i] > 0);
            req_data[i*8 +: 8] = {4'(i), 4'(seq[i])};
        end
        #1;
        c_wr   = fifo_wr;
        c_rdy  = req_ready;
        c_busy = busy;
        c_gid  = grant_id;
        c_data = fifo_data_in;
        if (full)    check("no_wr_when_full", 32'(c_wr), 32'(0));
        if (rst)     check("quiet_in_reset", 32'({c_wr, c_rdy, c_data}), 32'(0));
        if (!c_busy) check("no_wr_in_idle", 32'(c_wr), 32'(0));
        check("wr_eq_ready", 32'(c_wr), 32'(|c_rdy));
        check("ready_onehot", 32'($countones(c_rdy) <= 1), 32'(1));
        if (c_wr) begin
            check("ready_is_grant", 32'(c_rdy), 32'(4'b0001 << c_gid));
            check("data_word", 32'(c_data), 32'({4'(c_gid), 4'(seq[c_gid])}));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (c_rdy[i] && !rst) begin
                seq[i]++;
                rem[i]--;
            end
        end
    endtask

    task automatic expect_cyc(input string name, input logic rst, input logic full,
                              input logic e_wr, input logic e_busy,
                              input logic chk_gid, input logic [1:0] e_gid);
        tick(rst, full);
        check({name, "_wr"}, 32'(c_wr), 32'(e_wr));
        check({name, "_busy"}, 32'(c_busy), 32'(e_busy));
        if (chk_gid) check({name, "_gid"}, 32'(c_gid), 32'(e_gid));
    endtask

    task automatic do_reset();
        clr_model();
        tick(1'b1, 1'b0);
    endtask

    initial begin
        int run;
        int writes;
        int cyc;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;

        //          rst   valid    full  wr    rdy      data   busy  gid
        tv[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0};
        tv[1]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0};
        tv[2]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0};
        tv[3]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 8'hA0, 1'b1, 2'd0};
        tv[4]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 8'hA0, 1'b1, 2'd0};
        tv[5]  = '{1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 8'hA0, 1'b1, 2'd0};
        tv[6]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 8'hA0, 1'b1, 2'd0};
        tv[7]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0001, 8'hA0, 1'b1, 2'd0};
        tv[8]  = '{1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0};
        tv[9]  = '{1'b0, 4'b0101, 1'b0, 1'b1, 4'b0100, 8'hC2, 1'b1, 2'd2};
        tv[10] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'hC2, 1'b1, 2'd2};
        tv[11] = '{1'b0, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd2};
        tv[12] = '{1'b0, 4'b0001, 1'b0, 1'b1, 4'b0001, 8'hA0, 1'b1, 2'd0};
        tv[13] = '{1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b1, 2'd0};
        tv[14] = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0};
        tv[15] = '{1'b0, 4'b1010, 1'b0, 1'b1, 4'b0010, 8'hB1, 1'b1, 2'd1};
        tv[16] = '{1'b0, 4'b1010, 1'b1, 1'b0, 4'b0000, 8'hB1, 1'b1, 2'd1};

        @(posedge clk);
        #1;

        // Table: reset state, rotation, stall, holder drop, reset mid-burst.
        for (int v = 0; v < NV; v++) begin
            reset     = tv[v].rst;
            req_valid = tv[v].valid;
            fifo_full = tv[v].full;
            req_data  = 32'hD3C2B1A0;
            #1;
            check($sformatf("v%0d_wr", v),   32'(fifo_wr),      32'(tv[v].e_wr));
            check($sformatf("v%0d_rdy", v),  32'(req_ready),    32'(tv[v].e_rdy));
            check($sformatf("v%0d_data", v), 32'(fifo_data_in), 32'(tv[v].e_data));
            check($sformatf("v%0d_busy", v), 32'(busy),         32'(tv[v].e_busy));
            check($sformatf("v%0d_gid", v),  32'(grant_id),     32'(tv[v].e_gid));
            @(posedge clk);
            #1;
        end

        // Single producer, 10 words: bursts of 4, 4, 2 separated by IDLE.
        do_reset();
        rem[1] = 10;
        expect_cyc("p1_c0",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) expect_cyc("p1_b1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
        expect_cyc("p1_c5",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 4; k++) expect_cyc("p1_b2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
        expect_cyc("p1_c10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 2; k++) expect_cyc("p1_b3", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
        expect_cyc("p1_c13", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        expect_cyc("p1_c14", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("p1_words", 32'(seq[1]), 32'(10));

        // Full for 3 cycles after the 2nd word; burst still ends at 4 words.
        do_reset();
        rem[0] = 8;
        expect_cyc("st_c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_cyc("st_c1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        expect_cyc("st_c2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        for (int k = 0; k < 3; k++) expect_cyc("st_full", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0);
        expect_cyc("st_c6", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        expect_cyc("st_c7", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);
        expect_cyc("st_c8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("st_words", 32'(seq[0]), 32'(4));

        // Producer 3 drops after 2 words while producer 0 waits.
        do_reset();
        rem[3] = 2;
        expect_cyc("dr_c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        rem[0] = 4;
        expect_cyc("dr_c1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
        expect_cyc("dr_c2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
        expect_cyc("dr_c3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
        expect_cyc("dr_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_cyc("dr_c5", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0);

        // Reset during the 3rd word of a burst.
        do_reset();
        rem[2] = 8;
        expect_cyc("rs_c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_cyc("rs_c1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
        expect_cyc("rs_c2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
        expect_cyc("rs_c3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2);
        rem[1] = 4;
        expect_cyc("rs_c4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
        expect_cyc("rs_c5", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1);
        check("rs_words", 32'(seq[2]), 32'(2));

        // All producers, 16 tagged words each, random back-pressure.
        do_reset();
        for (int i = 0; i < 4; i++) rem[i] = 16;
        run    = 0;
        writes = 0;
        cyc    = 0;
        while ((rem[0] + rem[1] + rem[2] + rem[3]) > 0 && cyc < 2000) begin
            tick(1'b0, ($urandom_range(0, 3) == 0));
            cyc++;
            if (!c_busy) begin
                run = 0;
            end else if (c_wr) begin
                run++;
                writes++;
                check("burst_len", 32'(run <= 4), 32'(1));
            end
        end
        check("rnd_done_in_budget", 32'(cyc < 2000), 32'(1));
        check("rnd_total_writes", 32'(writes), 32'(64));
        for (int i = 0; i < 4; i++) check($sformatf("rnd_words_p%0d", i), 32'(seq[i]), 32'(16));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
